// File: rtl/riscv_core_rf_mp.sv
// riscv_core_rf_mp: multi-port integer register file for the RV32IMC pipeline.
// Two write ports (0 = WB, 1 = M-unit writeback), NRD combinational read ports,
// a post-reset init sequencer that loads sp/gp, a per-register pending
// scoreboard for long-latency M-ops and a registered write-conflict pulse.
// Optional feature macro: RF_BYPASS_EN (same-cycle write-to-read bypass).
module riscv_core_rf_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter logic [XLEN-1:0] SP_INIT = 32'h7FFF_FFF0,
    parameter logic [XLEN-1:0] GP_INIT = 32'h1000_0000,
    localparam int AW = $clog2(NREG)
) (
    input  logic                i_rf_clk,
    input  logic                i_rf_rst_n,
    input  logic [NRD*AW-1:0]   i_rf_ra,
    output logic [NRD*XLEN-1:0] o_rf_rd,
    output logic [NRD-1:0]      o_rf_busy,
    input  logic                i_rf_we0,
    input  logic [AW-1:0]       i_rf_wa0,
    input  logic [XLEN-1:0]     i_rf_wd0,
    input  logic                i_rf_we1,
    input  logic [AW-1:0]       i_rf_wa1,
    input  logic [XLEN-1:0]     i_rf_wd1,
    input  logic                i_rf_bset,
    input  logic [AW-1:0]       i_rf_baddr,
    output logic                o_rf_ready,
    output logic                o_rf_wconf
);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [AW-1:0] ZERO_A   = '0;

    state_t            state_reg, state_next;
    logic [AW-1:0]     idx_reg, idx_next;
    logic [NREG-1:0]   sb_reg, sb_next;
    logic              ready_reg;
    logic              wconf_reg;
    logic [XLEN-1:0]   mem [NREG];
    logic [XLEN-1:0]   init_val;
    logic              is_ready;
    logic              wr_en0;
    logic              wr_en1;
    logic              wconf_next;

    assign is_ready   = (state_reg == ST_READY);
    assign wr_en0     = is_ready && i_rf_we0 && (i_rf_wa0 != ZERO_A);
    assign wr_en1     = is_ready && i_rf_we1 && (i_rf_wa1 != ZERO_A);
    assign wconf_next = wr_en0 && wr_en1 && (i_rf_wa0 == i_rf_wa1);

    // State and init-index register; reset restarts the init sequence
    always_ff @(posedge i_rf_clk or negedge i_rf_rst_n) begin
        if (!i_rf_rst_n) begin
            state_reg <= ST_INIT;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state: walk every index once, then park in READY forever
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            ST_INIT: begin
                idx_next = idx_reg + AW'(1);
                if (idx_reg == LAST_IDX) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                state_next = ST_READY;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // Init value for the entry being loaded: sp and gp get their boot values
    always_comb begin
        init_val = '0;
        if (idx_reg == AW'(2)) begin
            init_val = SP_INIT;
        end else if (idx_reg == AW'(3)) begin
            init_val = GP_INIT;
        end
    end

    // Register array; port 0 is written last so it wins an address collision
    always_ff @(posedge i_rf_clk) begin
        if (!is_ready) begin
            mem[idx_reg] <= init_val;
        end else begin
            if (wr_en1) begin
                mem[i_rf_wa1] <= i_rf_wd1;
            end
            if (wr_en0) begin
                mem[i_rf_wa0] <= i_rf_wd0;
            end
        end
    end

    // Scoreboard update: M-unit writeback clears, a new issue sets (set wins)
    always_comb begin
        sb_next = sb_reg;
        if (wr_en1) begin
            sb_next[i_rf_wa1] = 1'b0;
        end
        if (is_ready && i_rf_bset && (i_rf_baddr != ZERO_A)) begin
            sb_next[i_rf_baddr] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Scoreboard, ready flag and write-conflict pulse registers
    always_ff @(posedge i_rf_clk or negedge i_rf_rst_n) begin
        if (!i_rf_rst_n) begin
            sb_reg    <= '0;
            ready_reg <= 1'b0;
            wconf_reg <= 1'b0;
        end else begin
            sb_reg    <= sb_next;
            ready_reg <= is_ready;
            wconf_reg <= wconf_next;
        end
    end

    assign o_rf_ready = ready_reg;
    assign o_rf_wconf = wconf_reg;

    // Per-port combinational read path with optional write-through bypass
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra_k;
            logic [XLEN-1:0] rd_k;
            logic            busy_k;

            assign ra_k = i_rf_ra[gi*AW +: AW];

            // Read data and busy for this port; everything reads 0 until READY
            always_comb begin
                rd_k   = '0;
                busy_k = 1'b0;
                if (is_ready && (ra_k != ZERO_A)) begin
                    rd_k   = mem[ra_k];
                    busy_k = sb_reg[ra_k];
`ifdef RF_BYPASS_EN
                    if (wr_en0 && (i_rf_wa0 == ra_k)) begin
                        rd_k = i_rf_wd0;
                    end else if (wr_en1 && (i_rf_wa1 == ra_k)) begin
                        rd_k = i_rf_wd1;
                    end
                    if (wr_en1 && (i_rf_wa1 == ra_k)) begin
                        busy_k = 1'b0;
                    end
`endif
                end
            end

            assign o_rf_rd[gi*XLEN +: XLEN] = rd_k;
            assign o_rf_busy[gi]            = busy_k;
        end
    endgenerate

endmodule

// File: doc/riscv_core_rf_mp.md
Name: riscv_core_rf_mp

Overview:
Parametrised multi-port integer register file for the RV32IMC pipeline.
- Configurable XLEN, register count, read-port count and two write ports: port 0 is the pipeline WB port, port 1 is the long-latency M-unit (mul/div) writeback.
- Adds a post-reset init sequencer, a per-register pending scoreboard, same-cycle write-to-read bypass and write-conflict detection.
- Sits in ID (reads) and WB (writes); the hazard unit consumes the ready and busy outputs.

Parameters:
XLEN, 32, data width in bits
NREG, 32, number of architectural registers (power of 2, ≥4); AW = $clog2(NREG)
NRD, 2, number of read ports (1..4)
SP_INIT, 32'h7FFF_FFF0, init value of x2 (sp)
GP_INIT, 32'h1000_0000, init value of x3 (gp)

Ports:
i_rf_clk  in  1  clock; all state updates on rising edge
i_rf_rst_n  in  1  asynchronous active-low reset
i_rf_ra  in  NRD*AW  packed read addresses, port k = bits [k*AW +: AW]
o_rf_rd  out  NRD*XLEN  packed read data, combinational
o_rf_busy  out  NRD  per-read-port flag: addressed register is pending
i_rf_we0  in  1  write enable, port 0 (WB)
i_rf_wa0  in  AW  write address, port 0
i_rf_wd0  in  XLEN  write data, port 0
i_rf_we1  in  1  write enable, port 1 (M-unit)
i_rf_wa1  in  AW  write address, port 1
i_rf_wd1  in  XLEN  write data, port 1
i_rf_bset  in  1  mark register pending (M-op issued)
i_rf_baddr  in  AW  register to mark pending
o_rf_ready  out  1  high once init is complete
o_rf_wconf  out  1  registered pulse: both ports wrote the same nonzero address last cycle

Behaviour:
- Reset (async assert, sync release): FSM → INIT, init index = 0, scoreboard all 0, o_rf_ready = 0, o_rf_wconf = 0.
- FSM INIT: each cycle writes entry[idx] = (idx==2 ? SP_INIT : idx==3 ? GP_INIT : 0) and increments idx.
  - After idx = NREG-1 is written, go to READY; o_rf_ready rises the following cycle.
  - Init therefore takes exactly NREG cycles after reset release.
- FSM READY: terminal state; only reset leaves it.
- During INIT:
  - All write ports and i_rf_bset are ignored.
  - o_rf_rd = 0 and o_rf_busy = 0 on every port.
- Reset asserted mid-INIT or mid-READY: FSM restarts INIT from idx 0; array contents are rewritten by the sequence.
- Writes (READY only) commit on the rising edge.
  - A write to x0 is discarded on either port.
  - Both ports writing the same nonzero address: port 0 wins; o_rf_wconf = 1 for one cycle. Otherwise o_rf_wconf = 0.
  - Different addresses: both commit.
- Reads are combinational.
  - Address 0 returns 0.
  - Otherwise returns array[ra], subject to bypass (see Optional Feature).
- Scoreboard (NREG bits; bit 0 is hard 0):
  - i_rf_bset with baddr ≠ 0 sets bit[baddr].
  - A port-1 write clears bit[wa1].
  - Set and clear on the same register in the same cycle: set wins (newer issue).
  - A port-0 write does not touch the scoreboard.
  - o_rf_busy[k] = bit[ra_k], combinational, no bypass of same-cycle set/clear.
- All outputs become valid 0 cycles after their inputs (combinational), except o_rf_ready and o_rf_wconf, which are registered.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined: write-through bypass.
  - A read whose nonzero address matches an enabled write in the same cycle returns that write data.
  - Port 0 data takes priority over port 1.
  - o_rf_busy[k] is forced to 0 when port 1 writes ra_k in that cycle.
- Undefined: no bypass; the written value is visible from the cycle after the edge, and busy clears one cycle after the port-1 write.
- Semantics are otherwise identical.

Test Plan:
- Release reset, hold 32 cycles → o_rf_ready rises in cycle 33; x2 reads 32'h7FFF_FFF0, x3 reads 32'h1000_0000, x5 reads 0; reads during INIT return 0.
- Ready state: we0, wa0=5, wd0=32'hDEAD_BEEF while ra0=5 → with RF_BYPASS_EN rd0 = DEADBEEF in the same cycle; without it rd0 = 0 that cycle and DEADBEEF the next.
- we0/we1 both to x7 (wd0=32'h11, wd1=32'h22) → x7 = 32'h11, o_rf_wconf = 1 for one cycle; same test on x0 → x0 stays 0, wconf = 0.
- bset baddr=9 → o_rf_busy = 1 for ra=9 next cycle; we1 wa1=9 wd1=32'h55 → busy clears (same cycle with bypass, next cycle without); x9 = 32'h55.
- Same-cycle bset baddr=4 and we1 wa1=4 → bit 4 stays set; bset baddr=0 → busy for ra=0 stays 0.
- Write x10 = 32'hA5A5_A5A5, assert rst_n low mid-INIT after the next release, release → full 32-cycle INIT replays, x10 reads 0, scoreboard clear, ready low until the sequence completes.
